// File: rtl/mips8_pkg.sv
// Shared constants and types for the 8-bit MIPS issue/stall logic.
package mips8_pkg;

  localparam logic [4:0] LOAD_OP_C  = 5'b10100;
  localparam logic [4:0] STORE_OP_C = 5'b10101;

  // Instruction field positions: [19:15] op, [14:10] rd, [9:5] rs1, [4:0] rs2/imm
  localparam int OP_HI  = 19;
  localparam int OP_LO  = 15;
  localparam int RD_HI  = 14;
  localparam int RD_LO  = 10;
  localparam int RS1_HI = 9;
  localparam int RS1_LO = 5;
  localparam int RS2_HI = 4;
  localparam int RS2_LO = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    STALL = 2'd2
  } state_e;

endpackage

// File: rtl/load_scoreboard.sv
// In-flight load tracker: LOAD_LAT-deep shift of {valid, rd}.
// A load sits in the shift for LOAD_LAT cycles after issue; any source that
// matches a live entry is a hazard that forwarding cannot cover yet.
module load_scoreboard
  import mips8_pkg::*;
#(
  parameter int LOAD_LAT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [4:0] push_rd,
  input  logic [4:0] src_a,
  input  logic       en_a,
  input  logic [4:0] src_b,
  input  logic       en_b,
  input  logic [4:0] src_c,
  input  logic       en_c,
  output logic       hazard,
  output logic       busy
);

  logic [LOAD_LAT-1:0]      vld_q, vld_d;
  logic [LOAD_LAT-1:0][4:0] rd_q, rd_d;

  // Shift every cycle regardless of stalls; loads to r0 never enter, so a
  // live entry always has a nonzero rd and an r0 source can never match.
  always_comb begin
    vld_d    = '0;
    rd_d     = '0;
    vld_d[0] = push & (push_rd != 5'd0);
    rd_d[0]  = push_rd;
    for (int i = 1; i < LOAD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      rd_d[i]  = rd_q[i-1];
    end
  end

  // Scoreboard register, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      rd_q  <= '0;
    end else begin
      vld_q <= vld_d;
      rd_q  <= rd_d;
    end
  end

  // Compare every live entry against every enabled source
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < LOAD_LAT; i++) begin
      if (vld_q[i] && ((en_a && (src_a == rd_q[i])) ||
                       (en_b && (src_b == rd_q[i])) ||
                       (en_c && (src_c == rd_q[i]))))
        hazard = 1'b1;
    end
  end

  assign busy = |vld_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Issue/stall sequencer in front of dependency_check_block.
// Optional feature macro: STALL_CNT_EN adds a saturating 16-bit stall_count port.
module pipeline_stall_controller
  import mips8_pkg::*;
#(
  parameter int         LOAD_LAT = 2,
  parameter logic [4:0] LOAD_OP  = LOAD_OP_C,
  parameter logic [4:0] STORE_OP = STORE_OP_C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] ins,
  input  logic        ins_valid,
  output logic        ins_ready,
  output logic        pc_en,
  output logic [19:0] issue_ins,
  output logic        issue_valid,
  output logic        bubble,
  output logic        busy
`ifdef STALL_CNT_EN
  ,
  output logic [15:0] stall_count
`endif
);

  logic [4:0]  op, rd, rs1, rs2;
  logic        is_load, use_rs2, use_rd, hazard, accept;
  state_e      state_q, state_d;
  logic [19:0] issue_ins_q, issue_ins_d;

  assign op  = ins[OP_HI:OP_LO];
  assign rd  = ins[RD_HI:RD_LO];
  assign rs1 = ins[RS1_HI:RS1_LO];
  assign rs2 = ins[RS2_HI:RS2_LO];

  // rs2 field is an immediate when op[4]=1; a store reads its rd field
  assign is_load = (op == LOAD_OP);
  assign use_rs2 = ~op[4];
  assign use_rd  = (op == STORE_OP);

  load_scoreboard #(.LOAD_LAT(LOAD_LAT)) u_sb (
    .clk    (clk),
    .rst_n  (reset),
    .push   (accept & is_load),
    .push_rd(rd),
    .src_a  (rs1),
    .en_a   (1'b1),
    .src_b  (rs2),
    .en_b   (use_rs2),
    .src_c  (rd),
    .en_c   (use_rd),
    .hazard (hazard),
    .busy   (busy)
  );

  assign ins_ready = reset & ~hazard;
  assign pc_en     = ins_valid & ins_ready;
  assign accept    = pc_en;

  // Next state and issue capture; state alone encodes issue_valid/bubble
  always_comb begin
    state_d     = IDLE;
    issue_ins_d = issue_ins_q;
    if (ins_valid) begin
      if (hazard) begin
        state_d = STALL;
      end else begin
        state_d     = ISSUE;
        issue_ins_d = ins;
      end
    end
  end

  // State and issue register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      issue_ins_q <= '0;
    end else begin
      state_q     <= state_d;
      issue_ins_q <= issue_ins_d;
    end
  end

  assign issue_ins   = issue_ins_q;
  assign issue_valid = (state_q == ISSUE);
  assign bubble      = (state_q == STALL);

`ifdef STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Count every registered bubble, saturating at all-ones
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_d == STALL) && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // Stall counter register, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller (LOAD_LAT=2): directed scenarios plus a
// randomized stream, all checked against a cycle-stamp model of pending loads.
module tb_pipeline_stall_controller;

  localparam int LAT = 2;
  localparam logic [4:0] LD = 5'b10100;
  localparam logic [4:0] ST = 5'b10101;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] ins;
  logic        ins_valid;
  logic        ins_ready, pc_en, issue_valid, bubble, busy;
  logic [19:0] issue_ins;
`ifdef STALL_CNT_EN
  logic [15:0] stall_count;
`endif

  pipeline_stall_controller #(.LOAD_LAT(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .ins        (ins),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .pc_en      (pc_en),
    .issue_ins  (issue_ins),
    .issue_valid(issue_valid),
    .bubble     (bubble),
    .busy       (busy)
`ifdef STALL_CNT_EN
    ,
    .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: cycle in which each register's latest load was accepted
  int          cyc = 0;
  int          last_load [32];
  int          last_any;
  logic        e_iv, e_bub;
  logic [19:0] e_ins;
  logic [15:0] e_cnt;

  int obs_bub, obs_stall, obs_iv, obs_busy, run, max_run;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int r = 0; r < 32; r++) last_load[r] = -100;
    last_any = -100;
    e_iv = 1'b0; e_bub = 1'b0; e_ins = '0; e_cnt = '0;
  endtask

  function automatic logic pending(input int c);
    return (cyc - c >= 1) && (cyc - c <= LAT);
  endfunction

  function automatic logic m_hazard(input logic [19:0] i);
    logic h;
    h = 1'b0;
    if (i[9:5] != 0 && pending(last_load[i[9:5]])) h = 1'b1;
    if (!i[19] && i[4:0] != 0 && pending(last_load[i[4:0]])) h = 1'b1;
    if (i[19:15] == ST && i[14:10] != 0 && pending(last_load[i[14:10]])) h = 1'b1;
    return h;
  endfunction

  task automatic clr_obs();
    obs_bub = 0; obs_stall = 0; obs_iv = 0; obs_busy = 0;
  endtask

  // One cycle: drive at negedge, check everything, let the edge happen, advance model
  task automatic step(input logic v, input logic [19:0] i, output logic acc);
    logic hz;
    @(negedge clk);
    ins_valid = v; ins = i;
    #1;
    hz  = m_hazard(i);
    acc = v && reset && !hz;
    chk("ins_ready", ins_ready, reset && !hz);
    chk("pc_en", pc_en, acc);
    chk("issue_valid", issue_valid, e_iv);
    chk("bubble", bubble, e_bub);
    chk("issue_ins", issue_ins, e_ins);
    chk("busy", busy, pending(last_any));
`ifdef STALL_CNT_EN
    chk("stall_count", stall_count, e_cnt);
`endif
    if (bubble === 1'b1) begin obs_bub++; run++; end else run = 0;
    if (run > max_run) max_run = run;
    if (v && pc_en !== 1'b1) obs_stall++;
    if (issue_valid === 1'b1) obs_iv++;
    if (busy === 1'b1) obs_busy++;
    @(posedge clk);
    if (reset) begin
      if (acc) begin
        e_iv = 1'b1; e_bub = 1'b0; e_ins = i;
        if (i[19:15] == LD && i[14:10] != 0) begin
          last_load[i[14:10]] = cyc;
          last_any = cyc;
        end
      end else if (v) begin
        e_iv = 1'b0; e_bub = 1'b1;
        if (e_cnt != 16'hFFFF) e_cnt++;
      end else begin
        e_iv = 1'b0; e_bub = 1'b0;
      end
    end
    cyc++;
  endtask

  // Present one instruction until accepted (bounded)
  task automatic present(input string tag, input logic [19:0] i);
    logic a;
    a = 1'b0;
    for (int k = 0; k < 8 && !a; k++) step(1'b1, i, a);
    chk({tag, "_accepted"}, a, 1'b1);
  endtask

  function automatic logic [19:0] rand_ins();
    logic [4:0] op;
    case ($urandom_range(0, 4))
      0: op = LD;
      1: op = ST;
      2: op = 5'b00000;
      3: op = 5'b11000;
      default: op = 5'($urandom_range(0, 31));
    endcase
    return {op, 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5))};
  endfunction

  localparam logic [19:0] ADD1 = 20'b00000_00001_00010_00011;
  localparam logic [19:0] ADD2 = 20'b00000_00110_00010_00011;
  localparam logic [19:0] LD4  = 20'b10100_00100_00001_00000;
  localparam logic [19:0] DEP  = 20'b00000_00101_00100_00011;
  localparam logic [19:0] STR4 = 20'b10101_00100_00010_00000;
  localparam logic [19:0] IMM  = 20'b11000_00111_00001_00100;
  localparam logic [19:0] LD0  = 20'b10100_00000_00001_00000;
  localparam logic [19:0] RD0  = 20'b00000_00101_00000_00000;

  initial begin
    logic a, pv;
    logic [19:0] pi;
    run = 0; max_run = 0;
    m_reset();
    clr_obs();

    // 1. reset held low with fetch presenting
    reset = 1'b0; ins_valid = 1'b1; ins = ADD1;
    for (int k = 0; k < 20; k++) step(1'b1, ADD1, a);
    chk("s1_reset_accepts", a, 1'b0);
    #2 reset = 1'b1;

    // 2. two independent ALU ops back to back
    clr_obs();
    step(1'b1, ADD1, a);
    chk("s1_accept_after_release", a, 1'b1);
    step(1'b1, ADD2, a);
    step(1'b0, '0, a);
    step(1'b0, '0, a);
    chk("s2_issued", obs_iv, 2);
    chk("s2_bubbles", obs_bub, 0);

    // 3. load then immediately dependent
    clr_obs();
    step(1'b1, LD4, a);
    present("s3_dep", DEP);
    step(1'b0, '0, a);
    chk("s3_bubbles", obs_bub, LAT);
    chk("s3_pc_stalls", obs_stall, LAT);
`ifdef STALL_CNT_EN
    chk("s3_stall_count", stall_count, 16'd2);
`endif
    step(1'b0, '0, a);
    step(1'b0, '0, a);

    // 4. store sourcing the loaded rd stalls; immediate form does not
    clr_obs();
    step(1'b1, LD4, a);
    present("s4_store", STR4);
    step(1'b0, '0, a);
    chk("s4_store_bubbles", obs_bub, 2);
    step(1'b0, '0, a);
    step(1'b0, '0, a);
    clr_obs();
    step(1'b1, LD4, a);
    present("s4_imm", IMM);
    step(1'b0, '0, a);
    chk("s4_imm_bubbles", obs_bub, 0);
    step(1'b0, '0, a);
    step(1'b0, '0, a);

    // 5. load to r0 is untracked
    clr_obs();
    step(1'b1, LD0, a);
    present("s5_rd0", RD0);
    step(1'b0, '0, a);
    chk("s5_bubbles", obs_bub, 0);
    chk("s5_busy_cycles", obs_busy, 0);

    // 6. reset asserted during the stall
    step(1'b1, LD4, a);
    step(1'b1, DEP, a);
    @(negedge clk);
    #1 chk("s6_bubble_before_reset", bubble, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("s6_busy_async", busy, 1'b0);
    chk("s6_bubble_async", bubble, 1'b0);
    chk("s6_ready_in_reset", ins_ready, 1'b0);
    chk("s6_pc_en_in_reset", pc_en, 1'b0);
    m_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    cyc++;
    clr_obs();
    present("s6_dep", DEP);
    step(1'b0, '0, a);
    chk("s6_bubbles_after_reset", obs_bub, 0);

    // Randomized stream; a stalled instruction is held until accepted
    pv = 1'b0; a = 1'b1; pi = '0;
    for (int k = 0; k < 600; k++) begin
      if (pv && !a) step(1'b1, pi, a);
      else begin
        pv = ($urandom_range(0, 9) != 0);
        pi = rand_ins();
        step(pv, pi, a);
      end
    end
    step(1'b0, '0, a);

    chk("max_stall_run_le_lat", max_run <= LAT, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
